// File: rtl/digital_bit_buffer_pkg.sv
// Shared constants, head FSM states and bit-order helper for the digital bit buffer.
// Build option: DIGITAL_BUF_LSB_FIRST_EN serves each byte LSB first instead of MSB first.
package digital_bit_buffer_pkg;

    localparam int DEPTH_BYTES = 2048;
    localparam int ADDR_W      = $clog2(DEPTH_BYTES);
    localparam int LEVEL_W     = 15;
    localparam int FULL_BITS   = DEPTH_BYTES * 8;
    localparam int ORB_BITS    = 10240;

    // A byte is accepted only while a whole byte of space remains.
    localparam logic [LEVEL_W-1:0] WR_LIMIT = LEVEL_W'(FULL_BITS - 8);

    typedef enum logic [1:0] {
        EMPTY,
        FETCH,
        LOAD,
        HOLD
    } head_state_e;

    function automatic logic head_bit(input logic [7:0] head, input logic [2:0] idx);
`ifdef DIGITAL_BUF_LSB_FIRST_EN
        return head[idx];
`else
        return head[3'd7 - idx];
`endif
    endfunction

endpackage

// File: rtl/digital_byte_ram.sv
// Simple dual-port byte RAM: one write port, one read port with a registered read.
module digital_byte_ram
    import digital_bit_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_BYTES,
    parameter int AW    = ADDR_W
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/digital_bit_buffer.sv
// Byte FIFO feeding the orbit word writer one bit per bitRequest rising edge.
// Build option: DIGITAL_BUF_LSB_FIRST_EN selects LSB-first bit order (see package).
module digital_bit_buffer
    import digital_bit_buffer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         byteData,
    input  logic               byteValid,
    input  logic               bitRequest,
    output logic               bitData,
    output logic [LEVEL_W-1:0] bitLevel,
    output logic               overflow,
    output logic               underflow
);

    head_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         head_q, head_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               req_old_q;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic       consume;
    logic       wr_ok;
    logic       rd_ok;
    logic [7:0] ram_rdata;

    assign consume = bitRequest & ~req_old_q;
    assign wr_ok   = byteValid && (level_q <= WR_LIMIT);
    assign rd_ok   = consume && (level_q != '0);

    // Read port always tracks the head byte pointer; FETCH/LOAD just wait out the latency.
    digital_byte_ram #(
        .DEPTH (DEPTH_BYTES),
        .AW    (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (byteData),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (byteValid && !wr_ok) begin
            overflow_d = 1'b1;
        end
        if (consume && (level_q == '0)) begin
            underflow_d = 1'b1;
        end

        case ({wr_ok, rd_ok})
            2'b10:   level_d = level_q + LEVEL_W'(8);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            2'b11:   level_d = level_q + LEVEL_W'(7);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        idx_d    = idx_q;
        head_d   = head_q;

        case (state_q)
            EMPTY: begin
                if (level_q != '0) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = LOAD;
                if (rd_ok) begin
                    idx_d = idx_q + 3'd1;
                end
            end
            LOAD: begin
                head_d  = ram_rdata;
                idx_d   = rd_ok ? 3'd1 : 3'd0;
                state_d = HOLD;
            end
            HOLD: begin
                if (rd_ok) begin
                    idx_d = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
                        // level_q > 1 here means a complete next byte is already stored.
                        state_d  = (level_q > LEVEL_W'(1)) ? FETCH : EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= EMPTY;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            idx_q       <= '0;
            head_q      <= '0;
            level_q     <= '0;
            req_old_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            idx_q       <= idx_d;
            head_q      <= head_d;
            level_q     <= level_d;
            req_old_q   <= bitRequest;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bitData   = (state_q == HOLD) ? head_bit(head_q, idx_q) : 1'b0;
    assign bitLevel  = level_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_digital_bit_buffer.sv
// Self-checking bench for digital_bit_buffer: vector table, directed corners, random vs queue model.
module tb_digital_bit_buffer;
    import digital_bit_buffer_pkg::*;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic [7:0]         byteData = 8'h00;
    logic               byteValid = 1'b0;
    logic               bitRequest = 1'b0;
    logic               bitData;
    logic [LEVEL_W-1:0] bitLevel;
    logic               overflow;
    logic               underflow;

    always #5 clk = ~clk;

    digital_bit_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .byteData   (byteData),
        .byteValid  (byteValid),
        .bitRequest (bitRequest),
        .bitData    (bitData),
        .bitLevel   (bitLevel),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: the stored bit stream as a queue in serving order.
    bit   mq[$];
    logic m_req_old = 1'b0;
    logic m_ovf = 1'b0;
    logic m_unf = 1'b0;

    // Per-cycle samples (DUT) and model snapshot for the same cycle.
    logic s_bit, s_ovf, s_unf;
    int   s_level;
    int   m_level_s;
    logic m_head_s, m_ovf_s, m_unf_s;

    typedef struct {
        logic       bv;
        logic [7:0] bd;
        logic       req;
        logic       chk_bit;
        logic       exp_bit;
        int         exp_level;
    } vec_t;

    vec_t vt[27];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        mq.delete();
        m_req_old = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic bv, input logic [7:0] bd, input logic req);
        int  pre;
        bit  consume;
        pre = mq.size();
        consume = req && !m_req_old;
        if (consume) begin
            if (pre > 0) void'(mq.pop_front());
            else m_unf = 1'b1;
        end
        if (bv) begin
            if (pre <= FULL_BITS - 8) begin
                for (int i = 0; i < 8; i++) begin
`ifdef DIGITAL_BUF_LSB_FIRST_EN
                    mq.push_back(bd[i]);
`else
                    mq.push_back(bd[7-i]);
`endif
                end
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_req_old = req;
    endtask

    // One clock: drive at posedge+1, sample at negedge, model advances at posedge.
    task automatic cyc(input logic bv, input logic [7:0] bd, input logic req);
        byteValid  = bv;
        byteData   = bd;
        bitRequest = req;
        @(negedge clk);
        s_bit     = bitData;
        s_level   = int'(bitLevel);
        s_ovf     = overflow;
        s_unf     = underflow;
        m_level_s = mq.size();
        m_head_s  = (mq.size() > 0) ? logic'(mq[0]) : 1'b0;
        m_ovf_s   = m_ovf;
        m_unf_s   = m_unf;
        @(posedge clk);
        model_step(bv, bd, req);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_level"}, s_level, m_level_s);
        chk({tag, "_overflow"}, {31'd0, s_ovf}, {31'd0, m_ovf_s});
        chk({tag, "_underflow"}, {31'd0, s_unf}, {31'd0, m_unf_s});
    endtask

    task automatic do_reset();
        byteValid  = 1'b0;
        bitRequest = 1'b0;
        byteData   = 8'h00;
        reset      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
    endtask

    task automatic orbit_pass(input int exp_level);
        for (int i = 0; i < 1400; i++) cyc(1'b1, 8'($urandom), 1'b0);
        repeat (4) cyc(1'b0, 8'h00, 1'b0);
        chk_model("orbit_fill");
        for (int i = 0; i < ORB_BITS; i++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("orbit_bit", {31'd0, s_bit}, {31'd0, m_head_s});
            cyc(1'b0, 8'h00, 1'b0);
            cyc(1'b0, 8'h00, 1'b0);
        end
        chk("orbit_end_level", s_level, exp_level);
        chk_model("orbit_end");
    endtask

    initial begin
        int a5_bits[8];
        int bits_3c[8];
        int nc;
        a5_bits = '{1, 0, 1, 0, 0, 1, 0, 1};
        bits_3c = '{0, 0, 1, 1, 1, 1, 0, 0};

        // Vector table: 0xA5 written once, eight consumes spaced 3 clocks from row 4.
        for (int r = 0; r < 27; r++) begin
            vt[r] = '{bv: 1'b0, bd: 8'h00, req: 1'b0, chk_bit: 1'b0, exp_bit: 1'b0, exp_level: 0};
            if (r == 0) begin
                vt[r].bv = 1'b1;
                vt[r].bd = 8'hA5;
                vt[r].chk_bit = 1'b1;
            end
            if (r >= 4 && ((r - 4) % 3 == 0) && ((r - 4) / 3 < 8)) begin
                vt[r].req = 1'b1;
                vt[r].chk_bit = 1'b1;
                vt[r].exp_bit = 1'(a5_bits[(r - 4) / 3]);
            end
            if (r == 26) vt[r].chk_bit = 1'b1;
            nc = (r <= 4) ? 0 : (((r - 2) / 3 > 8) ? 8 : (r - 2) / 3);
            vt[r].exp_level = (r == 0) ? 0 : 8 - nc;
        end

        // Reset values are visible while reset is held.
        #2;
        chk("reset_bitData", {31'd0, bitData}, 32'd0);
        chk("reset_bitLevel", {17'd0, bitLevel}, 32'd0);
        chk("reset_overflow", {31'd0, overflow}, 32'd0);
        chk("reset_underflow", {31'd0, underflow}, 32'd0);
        do_reset();

        for (int r = 0; r < 27; r++) begin
            cyc(vt[r].bv, vt[r].bd, vt[r].req);
            chk($sformatf("a5_level_row%0d", r), s_level, vt[r].exp_level);
            if (vt[r].chk_bit)
                chk($sformatf("a5_bit_row%0d", r), {31'd0, s_bit}, {31'd0, vt[r].exp_bit});
        end

        // Consume on an empty buffer.
        do_reset();
        cyc(1'b0, 8'h00, 1'b1);
        chk("unf_before", {31'd0, s_unf}, 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("unf_flag", {31'd0, s_unf}, 32'd1);
        chk("unf_level", s_level, 0);
        chk("unf_bitData", {31'd0, s_bit}, 32'd0);

        // Write coincident with a consume at level 20.
        do_reset();
        repeat (3) cyc(1'b1, 8'($urandom), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk("coin_bit", {31'd0, s_bit}, {31'd0, m_head_s});
            cyc(1'b0, 8'h00, 1'b0);
            cyc(1'b0, 8'h00, 1'b0);
        end
        cyc(1'b1, 8'h55, 1'b1);
        chk("coin_level_before", s_level, 20);
        cyc(1'b0, 8'h00, 1'b0);
        chk("coin_level_after", s_level, 27);

        // Fill to capacity, then one more byte.
        do_reset();
        for (int i = 0; i < DEPTH_BYTES; i++) cyc(1'b1, 8'($urandom), 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("full_level", s_level, FULL_BITS);
        chk("full_overflow", {31'd0, s_ovf}, 32'd0);
        cyc(1'b1, 8'hFF, 1'b0);
        cyc(1'b0, 8'h00, 1'b0);
        chk("ovf_level", s_level, FULL_BITS);
        chk("ovf_flag", {31'd0, s_ovf}, 32'd1);

        // Two orbit passes; the second crosses the write-pointer wrap.
        do_reset();
        orbit_pass(960);
        orbit_pass(1920);

        // Asynchronous reset in the middle of a stream.
        do_reset();
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'hC0, 1'b0);
        cyc(1'b1, 8'h22, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b0, 8'h00, 1'b0);
        chk("mid_level", s_level, 15);
        chk("mid_bitData", {31'd0, s_bit}, 32'd1);
        chk("mid_underflow", {31'd0, s_unf}, 32'd1);
        #3;
        reset = 1'b0;
        #1;
        chk("async_bitData", {31'd0, bitData}, 32'd0);
        chk("async_bitLevel", {17'd0, bitLevel}, 32'd0);
        chk("async_overflow", {31'd0, overflow}, 32'd0);
        chk("async_underflow", {31'd0, underflow}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        model_reset();
        cyc(1'b1, 8'h3C, 1'b0);
        repeat (3) cyc(1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, 8'h00, 1'b1);
            chk($sformatf("x3c_bit%0d", k), {31'd0, s_bit}, 32'(bits_3c[k]));
            cyc(1'b0, 8'h00, 1'b0);
            cyc(1'b0, 8'h00, 1'b0);
        end
        chk("x3c_level_end", s_level, 0);

        // Random traffic against the queue model with a well-behaved writer.
        do_reset();
        begin
            int   since_edge = 100;
            int   nz_age = 0;
            int   high_len = 0;
            logic req_prev = 1'b0;
            logic req, rising, bv;
            for (int n = 0; n < 4000; n++) begin
                since_edge++;
                nz_age = (mq.size() > 0) ? nz_age + 1 : 0;
                rising = 1'b0;
                if (req_prev && high_len < 2 && ($urandom % 2 == 0)) begin
                    req = 1'b1;
                end else if (!req_prev && since_edge >= 3 && mq.size() >= 2 &&
                             nz_age >= 4 && ($urandom % 3 == 0)) begin
                    req = 1'b1;
                    rising = 1'b1;
                    since_edge = 0;
                end else begin
                    req = 1'b0;
                end
                high_len = req ? high_len + 1 : 0;
                bv = ($urandom % 12 == 0);
                cyc(bv, 8'($urandom), req);
                chk_model("rand");
                if (rising) chk("rand_bit", {31'd0, s_bit}, {31'd0, m_head_s});
                req_prev = req;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
